// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing generator.
//   - Default 640x480@60 timing values.
//   - axis_total(): total count (active + porches + sync) of one axis.
//   - fits_width(): tells whether a value fits in a counter of a given width.
//   - scale_t: pixel-replication shift (pixel = 2^scale screen pixels).
package vga_pkg;

   localparam int unsigned DEF_H_ACTIVE = 32'd640;
   localparam int unsigned DEF_H_FP     = 32'd16;
   localparam int unsigned DEF_H_SYNC   = 32'd96;
   localparam int unsigned DEF_H_BP     = 32'd48;
   localparam int unsigned DEF_V_ACTIVE = 32'd480;
   localparam int unsigned DEF_V_FP     = 32'd10;
   localparam int unsigned DEF_V_SYNC   = 32'd2;
   localparam int unsigned DEF_V_BP     = 32'd33;
   localparam int unsigned DEF_CNT_W    = 32'd12;
   localparam int unsigned DEF_PREFETCH = 32'd2;

   typedef logic [1:0] scale_t;

   function automatic int unsigned axis_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   function automatic bit fits_width(input int unsigned value,
                                     input int unsigned width);
      return 64'(value) < (64'd1 << width);
   endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: a wrapping position counter with decoded flags.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   step      - advance the counter by one this cycle
//   count     - current position 0..TOTAL-1 (registered state)
//   wrap      - step is high and the counter is at its last position
//   active    - position is inside the active area (first on the axis)
//   sync      - sync level for the current position (POL when in sync)
module vga_axis_cnt
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FP     = DEF_H_FP,
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BP     = DEF_H_BP,
   parameter bit          POL    = 1'b0,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   output logic [CNT_W-1:0] count,
   output logic             wrap,
   output logic             active,
   output logic             sync
);

   localparam int unsigned      TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 32'd1);
   localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
   localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
   localparam logic [CNT_W-1:0] SYNC_LST = CNT_W'(ACTIVE + FP + SYNC - 32'd1);
   localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_r;
   logic             in_sync_s;

   // Decode wrap, active and sync from the current position
   always_comb begin
      in_sync_s = (count_r >= SYNC_BEG) && (count_r <= SYNC_LST);
      wrap      = step && (count_r == LAST);
      active    = (count_r < ACT_END);
      if (in_sync_s) begin
         sync = POL;
      end else begin
         sync = ~POL;
      end
   end

   // Position counter, wraps to zero after the last position
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= '0;
      end else if (wrap) begin
         count_r <= '0;
      end else if (step) begin
         count_r <= count_r + ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with frame-buffer prefetch.
// Ports:
//   i_clk_sys     - pixel clock
//   i_rst         - synchronous reset, active-high
//   i_en          - display enable, taken once per frame
//   i_scale       - pixel replication shift, taken once per frame
//   o_hs, o_vs    - sync outputs
//   o_de          - active-area data enable
//   o_x_cnt/o_y_cnt - raw counters
//   o_xpos/o_ypos - image coordinate of the displayed pixel (0 outside DE)
//   o_rd_req      - read strobe for the pixel shown PREFETCH cycles later
//   o_rd_x/o_rd_y - image coordinate for o_rd_req (0 when idle)
//   o_frame_start - pulse with the output for h=0, v=0
//   o_line_start  - pulse with the output for h=0
// All outputs are registered from the counter state and share one cycle
// of latency.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned PREFETCH = DEF_PREFETCH
) (
   input  logic             i_clk_sys,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [1:0]       i_scale,
   output logic             o_hs,
   output logic             o_vs,
   output logic             o_de,
   output logic [CNT_W-1:0] o_x_cnt,
   output logic [CNT_W-1:0] o_y_cnt,
   output logic [CNT_W-1:0] o_xpos,
   output logic [CNT_W-1:0] o_ypos,
   output logic             o_rd_req,
   output logic [CNT_W-1:0] o_rd_x,
   output logic [CNT_W-1:0] o_rd_y,
   output logic             o_frame_start,
   output logic             o_line_start
);

   localparam int unsigned      H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned      V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 32'd1);
   localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W:0]   PF_EXT   = (CNT_W+1)'(PREFETCH);
   localparam logic [CNT_W:0]   H_TOT_EX = (CNT_W+1)'(H_TOTAL);
   localparam logic [CNT_W-1:0] H_TOT_LO = CNT_W'(H_TOTAL);

   // Elaboration-time parameter checks
   if (PREFETCH > H_FP + H_SYNC + H_BP) begin : g_err_prefetch
      $error("vga_timing_gen: PREFETCH %0d exceeds horizontal blanking", PREFETCH);
   end
   if (!fits_width(H_TOTAL - 32'd1, CNT_W)) begin : g_err_h_width
      $error("vga_timing_gen: CNT_W %0d cannot hold H_TOTAL-1", CNT_W);
   end
   if (!fits_width(V_TOTAL - 32'd1, CNT_W)) begin : g_err_v_width
      $error("vga_timing_gen: CNT_W %0d cannot hold V_TOTAL-1", CNT_W);
   end

   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic             h_wrap, v_wrap, h_active, v_active, h_sync, v_sync;

   vga_axis_cnt #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
      .POL(HS_POL), .CNT_W(CNT_W)
   ) u_h_cnt (
      .clk(i_clk_sys), .rst(i_rst), .step(1'b1),
      .count(h_cnt), .wrap(h_wrap), .active(h_active), .sync(h_sync)
   );

   vga_axis_cnt #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
      .POL(VS_POL), .CNT_W(CNT_W)
   ) u_v_cnt (
      .clk(i_clk_sys), .rst(i_rst), .step(h_wrap),
      .count(v_cnt), .wrap(v_wrap), .active(v_active), .sync(v_sync)
   );

   logic             en_r;
   scale_t           scale_r;
   logic             line_zero_r;   // counter state is h=0
   logic             frame_zero_r;  // counter state is h=0, v=0
   logic             cfg_load_s;
   logic [CNT_W:0]   p_ext_s;
   logic [CNT_W-1:0] tgt_x_s, tgt_y_s;
   logic             de_s, rd_s;
   logic [CNT_W-1:0] xpos_s, ypos_s, rd_x_s, rd_y_s;

   // Track zero positions from the counter wraps so start pulses need no compare
   always_ff @(posedge i_clk_sys) begin
      if (i_rst) begin
         line_zero_r  <= 1'b1;
         frame_zero_r <= 1'b1;
      end else begin
         line_zero_r  <= h_wrap;
         frame_zero_r <= v_wrap;
      end
   end

   // The last line is always blanking, so its first pixel is a safe point to
   // take a new enable/scale; late prefetches on that line already see it.
   assign cfg_load_s = line_zero_r && (v_cnt == V_LAST);

   // Frame configuration latch
   always_ff @(posedge i_clk_sys) begin
      if (i_rst) begin
         en_r    <= 1'b0;
         scale_r <= 2'd0;
      end else if (cfg_load_s) begin
         en_r    <= i_en;
         scale_r <= i_scale;
      end else begin
         en_r    <= en_r;
         scale_r <= scale_r;
      end
   end

   // Prefetch target, DE and coordinates for the next output word
   always_comb begin
      p_ext_s = {1'b0, h_cnt} + PF_EXT;
      if (p_ext_s >= H_TOT_EX) begin
         // Modular subtract in CNT_W bits; the true result always fits
         tgt_x_s = p_ext_s[CNT_W-1:0] - H_TOT_LO;
         if (v_cnt == V_LAST) begin
            tgt_y_s = '0;
         end else begin
            tgt_y_s = v_cnt + ONE;
         end
      end else begin
         tgt_x_s = p_ext_s[CNT_W-1:0];
         tgt_y_s = v_cnt;
      end

      de_s = en_r && h_active && v_active;
      rd_s = en_r && (tgt_x_s < H_ACT) && (tgt_y_s < V_ACT);

      if (de_s) begin
         xpos_s = h_cnt >> scale_r;
         ypos_s = v_cnt >> scale_r;
      end else begin
         xpos_s = '0;
         ypos_s = '0;
      end

      if (rd_s) begin
         rd_x_s = tgt_x_s >> scale_r;
         rd_y_s = tgt_y_s >> scale_r;
      end else begin
         rd_x_s = '0;
         rd_y_s = '0;
      end
   end

   // Output register stage
   always_ff @(posedge i_clk_sys) begin
      if (i_rst) begin
         o_hs          <= ~HS_POL;
         o_vs          <= ~VS_POL;
         o_de          <= 1'b0;
         o_x_cnt       <= '0;
         o_y_cnt       <= '0;
         o_xpos        <= '0;
         o_ypos        <= '0;
         o_rd_req      <= 1'b0;
         o_rd_x        <= '0;
         o_rd_y        <= '0;
         o_frame_start <= 1'b0;
         o_line_start  <= 1'b0;
      end else begin
         o_hs          <= h_sync;
         o_vs          <= v_sync;
         o_de          <= de_s;
         o_x_cnt       <= h_cnt;
         o_y_cnt       <= v_cnt;
         o_xpos        <= xpos_s;
         o_ypos        <= ypos_s;
         o_rd_req      <= rd_s;
         o_rd_x        <= rd_x_s;
         o_rd_y        <= rd_y_s;
         o_frame_start <= frame_zero_r;
         o_line_start  <= line_zero_r;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced 24x13 raster.
// dut0: PREFETCH=2, active-low syncs.  dut1: PREFETCH=0, active-high syncs.
module tb_vga_timing_gen;

   localparam int HA = 16, HF = 2, HSY = 3, HB = 3, HT = 24;
   localparam int VA = 8,  VF = 1, VSY = 2, VB = 2, VT = 13;

   typedef struct packed {
      logic        hs, vs, de;
      logic [11:0] x_cnt, y_cnt, xpos, ypos;
      logic        rd_req;
      logic [11:0] rd_x, rd_y;
      logic        fs, ls;
   } out_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en;
   logic [1:0] scale;

   logic hs0, vs0, de0, rq0, fs0, ls0;
   logic [11:0] xc0, yc0, xp0, yp0, rx0, ry0;
   logic hs1, vs1, de1, rq1, fs1, ls1;
   logic [11:0] xc1, yc1, xp1, yp1, rx1, ry1;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12), .PREFETCH(2)
   ) dut0 (
      .i_clk_sys(clk), .i_rst(rst), .i_en(en), .i_scale(scale),
      .o_hs(hs0), .o_vs(vs0), .o_de(de0), .o_x_cnt(xc0), .o_y_cnt(yc0),
      .o_xpos(xp0), .o_ypos(yp0), .o_rd_req(rq0), .o_rd_x(rx0), .o_rd_y(ry0),
      .o_frame_start(fs0), .o_line_start(ls0)
   );

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12), .PREFETCH(0)
   ) dut1 (
      .i_clk_sys(clk), .i_rst(rst), .i_en(en), .i_scale(scale),
      .o_hs(hs1), .o_vs(vs1), .o_de(de1), .o_x_cnt(xc1), .o_y_cnt(yc1),
      .o_xpos(xp1), .o_ypos(yp1), .o_rd_req(rq1), .o_rd_x(rx1), .o_rd_y(ry1),
      .o_frame_start(fs1), .o_line_start(ls1)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   out_t q0[$];
   out_t q1[$];

   // reference state: counter position and latched frame config
   int mh = 0, mv = 0, msc = 0;
   bit men = 1'b0;

   function automatic out_t model(input int h, input int v, input bit e,
                                  input int sc, input int pf,
                                  input bit hp, input bit vpl);
      out_t o;
      int   p, tv;
      o       = '0;
      o.hs    = (h >= HA + HF && h < HA + HF + HSY) ? hp  : ~hp;
      o.vs    = (v >= VA + VF && v < VA + VF + VSY) ? vpl : ~vpl;
      o.x_cnt = 12'(h);
      o.y_cnt = 12'(v);
      o.de    = e && (h < HA) && (v < VA);
      if (o.de) begin
         o.xpos = 12'(h >> sc);
         o.ypos = 12'(v >> sc);
      end
      p  = h + pf;
      tv = v;
      if (p >= HT) begin
         p  = p - HT;
         tv = (v == VT - 1) ? 0 : v + 1;
      end
      o.rd_req = e && (p < HA) && (tv < VA);
      if (o.rd_req) begin
         o.rd_x = 12'(p >> sc);
         o.rd_y = 12'(tv >> sc);
      end
      o.fs = (h == 0) && (v == 0);
      o.ls = (h == 0);
      return o;
   endfunction

   function automatic out_t rst_out(input bit hp, input bit vpl);
      out_t o;
      o    = '0;
      o.hs = ~hp;
      o.vs = ~vpl;
      return o;
   endfunction

   // push the expected output of the coming edge, advance the model, clock
   task automatic step();
      out_t e0, e1;
      if (rst) begin
         e0 = rst_out(1'b0, 1'b0);
         e1 = rst_out(1'b1, 1'b1);
         mh = 0; mv = 0; men = 1'b0; msc = 0;
      end else begin
         e0 = model(mh, mv, men, msc, 2, 1'b0, 1'b0);
         e1 = model(mh, mv, men, msc, 0, 1'b1, 1'b1);
         if (mh == 0 && mv == VT - 1) begin
            men = en;
            msc = int'(scale);
         end
         mh = mh + 1;
         if (mh == HT) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end
      end
      q0.push_back(e0);
      q1.push_back(e1);
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int h, input int v);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!(mh == h && mv == v) && n < 1000);
      if (!(mh == h && mv == v)) begin
         n_tests++;
         n_fail++;
         $display("FAIL run_to timeout: at h=%0d v=%0d, wanted h=%0d v=%0d", mh, mv, h, v);
      end
   endtask

   // ---------------- monitor ----------------
   int  frame_idx = -1;
   int  de_cnt[8], hs_cnt[8], vs_cnt[8];
   int  max_rdx2 = 0, max_ypos2 = 0;
   bit  first_rd_seen = 1'b0;
   bit  rdv1 = 1'b0, rdv2 = 1'b0;
   logic [11:0] rx1h = 12'd0, ry1h = 12'd0, rx2h = 12'd0, ry2h = 12'd0;
   int  cyc = 0;

   initial begin
      out_t got0, got1, e;
      for (int i = 0; i < 8; i++) begin
         de_cnt[i] = 0; hs_cnt[i] = 0; vs_cnt[i] = 0;
      end
      forever begin
         @(posedge clk);
         #3;
         cyc++;
         got0 = {hs0, vs0, de0, xc0, yc0, xp0, yp0, rq0, rx0, ry0, fs0, ls0};
         got1 = {hs1, vs1, de1, xc1, yc1, xp1, yp1, rq1, rx1, ry1, fs1, ls1};
         if (q0.size() > 0) begin
            e = q0.pop_front();
            n_tests++;
            if (got0 !== e) begin
               n_fail++;
               $display("FAIL dut0_out cyc=%0d got=%h exp=%h", cyc, got0, e);
            end
            // DE must match the read issued two cycles earlier
            if (de0) begin
               n_tests++;
               if (!(rdv2 && rx2h == xp0 && ry2h == yp0)) begin
                  n_fail++;
                  $display("FAIL rd_to_de cyc=%0d xpos=%0d ypos=%0d rd(-2) v=%0d x=%0d y=%0d",
                           cyc, xp0, yp0, rdv2, rx2h, ry2h);
               end
            end
            if (rq0 && !first_rd_seen) begin
               first_rd_seen = 1'b1;
               n_tests++;
               if (!(xc0 == 12'd22 && yc0 == 12'd12 && rx0 == 12'd0 && ry0 == 12'd0)) begin
                  n_fail++;
                  $display("FAIL first_rd got h=%0d v=%0d rd_x=%0d rd_y=%0d exp h=22 v=12 rd 0,0",
                           xc0, yc0, rx0, ry0);
               end
            end
            rdv2 = rdv1; rx2h = rx1h; ry2h = ry1h;
            rdv1 = rq0;  rx1h = rx0;  ry1h = ry0;
            if (fs0) frame_idx++;
            if (frame_idx >= 0 && frame_idx < 8) begin
               if (de0)  de_cnt[frame_idx]++;
               if (!hs0) hs_cnt[frame_idx]++;
               if (!vs0) vs_cnt[frame_idx]++;
               if (frame_idx == 2) begin
                  if (rq0 && int'(rx0) > max_rdx2) max_rdx2 = int'(rx0);
                  if (de0 && int'(yp0) > max_ypos2) max_ypos2 = int'(yp0);
               end
            end
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            n_tests++;
            if (got1 !== e) begin
               n_fail++;
               $display("FAIL dut1_out cyc=%0d got=%h exp=%h", cyc, got1, e);
            end
         end
      end
   end

   task automatic check_int(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; en = 1'b1; scale = 2'd0;
      step(); step(); step();
      rst = 1'b0;
      run_to(0, 0);              // frame 0 done (enable latched at its end)
      scale = 2'd1;
      run_to(0, 0);              // frame 1 done, scale 1 for frame 2
      run_to(0, 4);
      en = 1'b0;                 // frame 2 keeps DE, frame 3 blank
      run_to(0, 0);
      en = 1'b1; scale = 2'd0;
      run_to(0, 0);              // frame 4 starts
      run_to(10, 5);
      rst = 1'b1;
      step(); step(); step();
      rst = 1'b0;
      run_to(0, 0);              // frame 5 blank after reset
      run_to(0, 0);              // frame 6 enabled
      for (int i = 0; i < 5; i++) step();
      @(posedge clk);
      #5;

      check_int("queue0_drained", q0.size(), 0);
      check_int("de_frame0", de_cnt[0], 0);
      check_int("de_frame1", de_cnt[1], 128);
      check_int("de_frame2", de_cnt[2], 128);
      check_int("de_frame3", de_cnt[3], 0);
      check_int("de_frame4_cut", de_cnt[4], 90);
      check_int("de_frame5", de_cnt[5], 0);
      check_int("de_frame6", de_cnt[6], 128);
      check_int("hs_low_frame1", hs_cnt[1], 39);
      check_int("vs_low_frame1", vs_cnt[1], 48);
      check_int("hs_low_frame3", hs_cnt[3], 39);
      check_int("max_rd_x_scale1", max_rdx2, 7);
      check_int("max_ypos_scale1", max_ypos2, 3);
      check_int("first_rd_found", int'(first_rd_seen), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
